// File: rtl/z80_mini_com_pkg.sv
// Shared definitions for the z80_mini_com reset logic: sequencer states,
// reset cause codes and a counter-width helper.
package z80_mini_com_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } rst_state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Bits needed for a counter that runs from 0 to n-1 (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z80_btn_debounce.sv
// Reset pushbutton conditioning: 2-flop synchroniser followed by a symmetric
// debounce counter; btn_pressed changes only after DEB_CYCLES agreeing samples.
module z80_btn_debounce
  import z80_mini_com_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_pressed
);

  localparam int DW = cnt_bits(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [DW-1:0] cnt_reg;
  logic [DW-1:0] cnt_next;
  logic          pressed_reg;
  logic          pressed_next;
  logic          sample_low;

  assign sample_low = ~sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b00;
      cnt_reg     <= '0;
      pressed_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], btn_n};
      cnt_reg     <= cnt_next;
      pressed_reg <= pressed_next;
    end
  end

  // The counter tracks the run of samples that disagree with the current
  // debounced state; any agreeing sample restarts the run.
  always_comb begin
    pressed_next = pressed_reg;
    cnt_next     = '0;
    if (sample_low != pressed_reg) begin
      if (cnt_reg == DEB_LAST) begin
        pressed_next = sample_low;
      end else begin
        cnt_next = cnt_reg + DW'(1);
      end
    end
  end

  assign btn_pressed = pressed_reg;

endmodule

// File: rtl/z80_reset_seq.sv
// Reset sequencer: holds all domains low, then releases them in staggered order
// and records the reset cause. Optional watchdog reset under `RST_WDT_EN.
module z80_reset_seq
  import z80_mini_com_pkg::*;
#(
  parameter int CH_NUM         = 3,
  parameter int HOLD_CYCLES    = 1000,
  parameter int STAGGER_CYCLES = 64,
  parameter int DEB_CYCLES     = 16,
  parameter int CNT_W          = 16,
  parameter int WDT_CYCLES     = 40000
) (
  input  logic              CLK50M,
  input  logic              n_RST,
  input  logic              btn_n_rst,
`ifdef RST_WDT_EN
  input  logic              wdt_kick,
`endif
  output logic [CH_NUM-1:0] n_rst_out,
  output logic              rst_busy,
  output logic [1:0]        rst_cause
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'((CH_NUM - 1) * STAGGER_CYCLES);

  if (HOLD_CYCLES < 1 ||
      longint'(HOLD_CYCLES + (CH_NUM - 1) * STAGGER_CYCLES) > CNT_MAX ||
      longint'(WDT_CYCLES) > CNT_MAX) begin : g_bad_cfg
    $error("z80_reset_seq: HOLD_CYCLES must be >= 1 and all delays must fit in CNT_W bits");
  end

  logic [1:0]        sync_n_reg;
  logic              sync_n;
  logic              btn_pressed;
  logic              wdt_expire;
  rst_state_t        state_reg;
  rst_state_t        state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [CH_NUM-1:0] out_reg;
  logic [CH_NUM-1:0] out_next;
  logic [CH_NUM-1:0] rel_hit;
  logic [1:0]        cause_reg;
  logic [1:0]        cause_next;

  always_ff @(posedge CLK50M or negedge n_RST) begin
    if (!n_RST) begin
      sync_n_reg <= 2'b00;
    end else begin
      sync_n_reg <= {sync_n_reg[0], 1'b1};
    end
  end

  assign sync_n = sync_n_reg[1];

  z80_btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk         (CLK50M),
    .rst_n       (n_RST),
    .btn_n       (btn_n_rst),
    .btn_pressed (btn_pressed)
  );

  // Channel gi is released on the STAGGER edge whose count equals its offset.
  genvar gi;
  for (gi = 0; gi < CH_NUM; gi++) begin : g_rel
    localparam logic [CNT_W-1:0] OFS = CNT_W'(gi * STAGGER_CYCLES);
    assign rel_hit[gi] = (cnt_reg == OFS);
  end

`ifdef RST_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] wdt_cnt_reg;
  logic [CNT_W-1:0] wdt_cnt_next;

  always_ff @(posedge CLK50M or negedge n_RST) begin
    if (!n_RST) begin
      wdt_cnt_reg <= '0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_next;
    end
  end

  // Held at zero outside RUN, so it starts fresh every time RUN is entered.
  always_comb begin
    wdt_cnt_next = '0;
    if (state_reg == RUN && !wdt_kick) begin
      wdt_cnt_next = wdt_cnt_reg + CNT_W'(1);
    end
  end

  assign wdt_expire = (state_reg == RUN) && (wdt_cnt_reg == WDT_LAST) && !wdt_kick;
`else
  assign wdt_expire = 1'b0;
`endif

  always_ff @(posedge CLK50M or negedge n_RST) begin
    if (!n_RST) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      out_reg   <= '0;
      cause_reg <= CAUSE_POR;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    cause_next = cause_reg;

    // The button wins over a watchdog expiry on the same edge.
    if (btn_pressed) begin
      cause_next = CAUSE_BTN;
    end else if (wdt_expire) begin
      cause_next = CAUSE_WDT;
    end

    case (state_reg)
      HOLD: begin
        out_next = '0;
        if (!sync_n || btn_pressed) begin
          cnt_next = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = STAGGER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STAGGER: begin
        if (btn_pressed) begin
          state_next = HOLD;
          cnt_next   = '0;
          out_next   = '0;
        end else begin
          out_next = out_reg | rel_hit;
          if (cnt_reg == STG_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (btn_pressed || wdt_expire) begin
          state_next = HOLD;
          cnt_next   = '0;
          out_next   = '0;
        end
      end
      default: begin
        state_next = HOLD;
        cnt_next   = '0;
        out_next   = '0;
      end
    endcase
  end

  assign n_rst_out = out_reg;
  assign rst_busy  = ~&out_reg;
  assign rst_cause = cause_reg;

endmodule

// File: tb/tb_z80_reset_seq.sv
// Self-checking bench for z80_reset_seq against an age-based reference model.
module tb_z80_reset_seq;

  localparam int CH   = 3;
  localparam int HOLD = 8;
  localparam int STG  = 4;
  localparam int DEB  = 3;
  localparam int CW   = 16;
  localparam int WDT  = 50;
`ifdef RST_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic          CLK50M = 1'b0;
  logic          n_RST;
  logic          btn_n_rst;
  logic          wdt_kick;
  logic [CH-1:0] n_rst_out;
  logic          rst_busy;
  logic [1:0]    rst_cause;

  int checks = 0;
  int errors = 0;

  always #10 CLK50M = ~CLK50M;

  z80_reset_seq #(
    .CH_NUM         (CH),
    .HOLD_CYCLES    (HOLD),
    .STAGGER_CYCLES (STG),
    .DEB_CYCLES     (DEB),
    .CNT_W          (CW),
    .WDT_CYCLES     (WDT)
  ) dut (
    .CLK50M    (CLK50M),
    .n_RST     (n_RST),
    .btn_n_rst (btn_n_rst),
`ifdef RST_WDT_EN
    .wdt_kick  (wdt_kick),
`endif
    .n_rst_out (n_rst_out),
    .rst_busy  (rst_busy),
    .rst_cause (rst_cause)
  );

  // Reference model: r_m = edges since n_RST rose, t_m = edges of uninterrupted
  // qualified hold time; channel i is released once t_m exceeds HOLD + i*STG.
  int         r_m;
  int         t_m;
  int         wd_m;
  bit         p_m;
  bit         b1;
  bit         b2;
  bit         win[$];
  logic [1:0] cause_m;

  task automatic model_reset();
    r_m = 0; t_m = 0; wd_m = 0; p_m = 0; b1 = 1; b2 = 1;
    win.delete();
    cause_m = 2'b00;
  endtask

  task automatic model_step();
    bit sync_old, samp, in_run, ev_btn, ev_wdt, all0, all1;
    if (!n_RST) begin
      model_reset();
      return;
    end
    if (r_m < 1000) r_m++;
    sync_old = (r_m >= 3);
    samp     = (r_m >= 3) ? b2 : 1'b0;
    b2 = b1;
    b1 = btn_n_rst;
    in_run = (t_m > HOLD + (CH - 1) * STG);
    ev_btn = p_m;
    ev_wdt = WDT_ON && in_run && (wd_m == WDT - 1) && !wdt_kick;
    if (ev_btn) cause_m = 2'b01;
    else if (ev_wdt) cause_m = 2'b10;
    if (ev_btn || ev_wdt || !sync_old) t_m = 0;
    else if (t_m < 1000) t_m++;
    wd_m = (in_run && !wdt_kick) ? wd_m + 1 : 0;
    win.push_back(samp);
    if (win.size() > DEB) void'(win.pop_front());
    if (win.size() == DEB) begin
      all0 = 1; all1 = 1;
      foreach (win[k]) begin
        if (win[k]) all0 = 0;
        else all1 = 0;
      end
      if (all0) p_m = 1;
      else if (all1) p_m = 0;
    end
  endtask

  function automatic logic [CH+2:0] exp_vec();
    logic [CH-1:0] o;
    for (int i = 0; i < CH; i++) o[i] = (t_m > HOLD + i * STG);
    return {o, ~&o, cause_m};
  endfunction

  task automatic step();
    @(posedge CLK50M);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int rise[CH];
    int busy_fall;
    n_RST = 0; btn_n_rst = 1; wdt_kick = 0;
    model_reset();
    repeat (20) begin
      step();
      checks++;
      if (n_rst_out !== 3'b000 || rst_busy !== 1'b1 || rst_cause !== 2'b00)
        begin errors++; $display("FAIL reset_hold: out=%b busy=%b cause=%b want 000/1/00", n_rst_out, rst_busy, rst_cause); end
    end
    n_RST = 1;
    foreach (rise[i]) rise[i] = -1;
    busy_fall = -1;
    repeat (40) begin
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL power_on_seq: got %b want %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
      for (int i = 0; i < CH; i++) if (n_rst_out[i] === 1'b1 && rise[i] < 0) rise[i] = r_m - 3;
      if (rst_busy === 1'b0 && busy_fall < 0) busy_fall = r_m - 3;
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (rise[i] != HOLD + i * STG)
        begin errors++; $display("FAIL power_on_rise%0d: edge %0d want %0d", i, rise[i], HOLD + i * STG); end
    end
    checks++;
    if (busy_fall != HOLD + (CH - 1) * STG || rst_cause !== 2'b00)
      begin errors++; $display("FAIL power_on_busy: edge %0d cause %b want %0d/00", busy_fall, rst_cause, HOLD + (CH - 1) * STG); end
  endtask

  task automatic test_mid_release();
    int rise[CH];
    n_RST = 0; model_reset();
    repeat (2) step();
    n_RST = 1;
    while (r_m < 13) begin
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL mid_pre: got %b want %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
    end
    checks++;
    if (n_rst_out !== 3'b001)
      begin errors++; $display("FAIL mid_edge10: out=%b want 001", n_rst_out); end
    #4 n_RST = 0;
    #1;
    checks++;
    if (n_rst_out !== 3'b000 || rst_busy !== 1'b1 || rst_cause !== 2'b00)
      begin errors++; $display("FAIL mid_async: out=%b busy=%b cause=%b want 000/1/00", n_rst_out, rst_busy, rst_cause); end
    model_reset();
    #4 n_RST = 1;
    foreach (rise[i]) rise[i] = -1;
    repeat (30) begin
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL mid_repeat: got %b want %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
      for (int i = 0; i < CH; i++) if (n_rst_out[i] === 1'b1 && rise[i] < 0) rise[i] = r_m - 3;
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (rise[i] != HOLD + i * STG)
        begin errors++; $display("FAIL mid_rise%0d: edge %0d want %0d", i, rise[i], HOLD + i * STG); end
    end
  endtask

  task automatic test_btn_glitch();
    int len;
    repeat (4) begin
      len = $urandom_range(1, DEB - 1);
      btn_n_rst = 0;
      for (int k = 0; k < len + 8; k++) begin
        if (k == len) btn_n_rst = 1;
        step();
        checks++;
        if (n_rst_out !== 3'b111 || rst_cause !== 2'b00 || {n_rst_out, rst_busy, rst_cause} !== exp_vec())
          begin errors++; $display("FAIL btn_glitch len %0d: got %b want 111_0_00", len, {n_rst_out, rst_busy, rst_cause}); end
      end
    end
  endtask

  task automatic test_btn_press(input int len);
    int rise[CH];
    int fall_k;
    foreach (rise[i]) rise[i] = -1;
    fall_k = -1;
    btn_n_rst = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == len + 1) btn_n_rst = 1;
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL btn_press_seq: got %b want %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
      if (fall_k < 0) begin
        if (n_rst_out === 3'b000) fall_k = k;
      end else begin
        for (int i = 0; i < CH; i++) if (n_rst_out[i] === 1'b1 && rise[i] < 0) rise[i] = k;
      end
    end
    checks++;
    if (fall_k != DEB + 3 || rst_cause !== 2'b01)
      begin errors++; $display("FAIL btn_press_fall: step %0d cause %b want %0d/01", fall_k, rst_cause, DEB + 3); end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (rise[i] != len + DEB + 3 + HOLD + i * STG)
        begin errors++; $display("FAIL btn_press_rise%0d: step %0d want %0d", i, rise[i], len + DEB + 3 + HOLD + i * STG); end
    end
  endtask

  task automatic test_btn_stagger();
    int a;
    int len;
    int e;
    a = $urandom_range(8, 11);
    len = DEB + $urandom_range(0, 3);
    n_RST = 0; model_reset();
    repeat (2) step();
    n_RST = 1;
    repeat (60) begin
      e = r_m - 2;
      if (e == a) btn_n_rst = 0;
      if (e == a + len) btn_n_rst = 1;
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL stagger_seq: got %b want %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
      if (e == a + 4) begin
        checks++;
        if (n_rst_out !== 3'b011)
          begin errors++; $display("FAIL stagger_before: out=%b want 011", n_rst_out); end
      end
      if (e == a + 5) begin
        checks++;
        if (n_rst_out !== 3'b000 || rst_cause !== 2'b01)
          begin errors++; $display("FAIL stagger_abort: out=%b cause=%b want 000/01", n_rst_out, rst_cause); end
      end
      if (e == a + len + 12 || e == a + len + 13) begin
        checks++;
        if (n_rst_out !== ((e == a + len + 13) ? 3'b001 : 3'b000))
          begin errors++; $display("FAIL stagger_rehold: edge %0d out=%b", e, n_rst_out); end
      end
    end
  endtask

`ifdef RST_WDT_EN
  task automatic test_watchdog();
    int iv;
    int hit;
    for (int n = 0; n < 3; n++) begin
      iv = (n == 0) ? 40 : $urandom_range(30, 45);
      for (int k = 1; k <= iv; k++) begin
        wdt_kick = (k == iv);
        step();
        checks++;
        if (n_rst_out !== 3'b111 || {n_rst_out, rst_busy, rst_cause} !== exp_vec())
          begin errors++; $display("FAIL wdt_kicked: got %b want 111 and %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
      end
      wdt_kick = 0;
    end
    hit = -1;
    for (int j = 1; j <= 60; j++) begin
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL wdt_expire_seq: got %b want %b", {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
      if (hit < 0 && n_rst_out === 3'b000) hit = j;
    end
    checks++;
    if (hit != WDT || rst_cause !== 2'b10)
      begin errors++; $display("FAIL wdt_timeout: step %0d cause %b want %0d/10", hit, rst_cause, WDT); end
  endtask
`endif

  task automatic test_random();
    int hold_left;
    hold_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold_left == 0) begin
        btn_n_rst = ~btn_n_rst;
        hold_left = btn_n_rst ? $urandom_range(1, 40) : $urandom_range(1, 8);
      end
      hold_left--;
      wdt_kick = ($urandom_range(0, 29) == 0);
      if (i == 300) begin
        n_RST = 0;
        model_reset();
      end
      if (i == 302) n_RST = 1;
      step();
      checks++;
      if ({n_rst_out, rst_busy, rst_cause} !== exp_vec())
        begin errors++; $display("FAIL random_seq at %0d: got %b want %b", i, {n_rst_out, rst_busy, rst_cause}, exp_vec()); end
    end
    wdt_kick = 0;
    btn_n_rst = 1;
  endtask

  initial begin
    test_reset();
    test_mid_release();
    test_btn_glitch();
    test_btn_press(10);
    test_btn_press($urandom_range(DEB, 12));
    test_btn_stagger();
`ifdef RST_WDT_EN
    test_watchdog();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
